// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// ALU operation codes, opcode/func values and datapath mux select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        SIF  = 3'd0,
        SID  = 3'd1,
        SEXE = 3'd2,
        SMEM = 3'd3,
        SWB  = 3'd4
    } state_e;

    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_SUB  = 4'b0100;
    localparam logic [3:0] ALUC_AND  = 4'b0001;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0010;
    localparam logic [3:0] ALUC_LUI  = 4'b0110;
    localparam logic [3:0] ALUC_SLL  = 4'b0011;
    localparam logic [3:0] ALUC_SRL  = 4'b0111;
    localparam logic [3:0] ALUC_SRA  = 4'b1111;
    localparam logic [3:0] ALUC_HAMD = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_HAMD = 6'b110000;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Instruction-class flags produced by the decoder; exactly one class bit
    // (rtype/itype/load/store/branch/jump/jal/jr/illegal) is set per opcode.
    typedef struct packed {
        logic rtype;
        logic shift;
        logic itype;
        logic load;
        logic store;
        logic branch;
        logic bne;
        logic jump;
        logic jal;
        logic jr;
        logic sext;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder: instruction-class flags plus the ALU
// operation. MC_CTRL_HAMD_EN makes R-type func 110000 a legal instruction.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o,
    output logic [3:0] aluc_o
);

    always_comb begin
        // NOTE: every output is defaulted before the case so no path can infer a latch.
        dec_o  = '0;
        aluc_o = ALUC_ADD;
        case (op_i)
            OP_RTYPE: begin
                dec_o.rtype = 1'b1;
                case (func_i)
                    FN_ADD: aluc_o = ALUC_ADD;
                    FN_SUB: aluc_o = ALUC_SUB;
                    FN_AND: aluc_o = ALUC_AND;
                    FN_OR:  aluc_o = ALUC_OR;
                    FN_XOR: aluc_o = ALUC_XOR;
                    FN_SLL: begin
                        aluc_o      = ALUC_SLL;
                        dec_o.shift = 1'b1;
                    end
                    FN_SRL: begin
                        aluc_o      = ALUC_SRL;
                        dec_o.shift = 1'b1;
                    end
                    FN_SRA: begin
                        aluc_o      = ALUC_SRA;
                        dec_o.shift = 1'b1;
                    end
                    FN_JR: begin
                        dec_o.rtype = 1'b0;
                        dec_o.jr    = 1'b1;
                    end
`ifdef MC_CTRL_HAMD_EN
                    FN_HAMD: aluc_o = ALUC_HAMD;
`endif
                    default: begin
                        dec_o.rtype   = 1'b0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_o.itype = 1'b1;
                dec_o.sext  = 1'b1;
            end
            OP_ANDI: begin
                dec_o.itype = 1'b1;
                aluc_o      = ALUC_AND;
            end
            OP_ORI: begin
                dec_o.itype = 1'b1;
                aluc_o      = ALUC_OR;
            end
            OP_XORI: begin
                dec_o.itype = 1'b1;
                aluc_o      = ALUC_XOR;
            end
            OP_LUI: begin
                dec_o.itype = 1'b1;
                aluc_o      = ALUC_LUI;
            end
            OP_LW: begin
                dec_o.load = 1'b1;
                dec_o.sext = 1'b1;
            end
            OP_SW: begin
                dec_o.store = 1'b1;
                dec_o.sext  = 1'b1;
            end
            OP_BEQ: begin
                dec_o.branch = 1'b1;
                aluc_o       = ALUC_SUB;
            end
            OP_BNE: begin
                dec_o.branch = 1'b1;
                dec_o.bne    = 1'b1;
                aluc_o       = ALUC_SUB;
            end
            OP_J:    dec_o.jump    = 1'b1;
            OP_JAL:  dec_o.jal     = 1'b1;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit: state register plus combinational datapath
// controls. Optional build macro: MC_CTRL_HAMD_EN (enables R-type func 110000).
module mc_control
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       jal,
    output logic [3:0] aluc,
    output logic [2:0] state
);

    state_e     state_q;
    state_e     state_d;
    dec_t       dec;
    logic [3:0] dec_aluc;
    logic       wpc_c;
    logic       wir_c;
    logic       wmem_c;
    logic       wreg_c;

    mc_decode u_decode (
        .op_i   (op),
        .func_i (func),
        .dec_o  (dec),
        .aluc_o (dec_aluc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!resetn) begin
            state_q <= SIF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = SIF;
        wpc_c    = 1'b0;
        wir_c    = 1'b0;
        wmem_c   = 1'b0;
        wreg_c   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        sext     = 1'b0;
        pcsource = PC_ALU;
        jal      = 1'b0;
        aluc     = ALUC_ADD;
        case (state_q)
            SIF: begin
                wpc_c   = 1'b1;
                wir_c   = 1'b1;
                alusrcb = SRCB_FOUR;
                state_d = SID;
            end
            SID: begin
                // PC + (imm<<2) is computed here so the branch target is ready in SEXE.
                alusrcb = SRCB_BR;
                sext    = 1'b1;
                if (dec.illegal) begin
                    state_d = SIF;
                end else if (dec.jump || dec.jal) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_JUMP;
                    wreg_c   = dec.jal;
                    jal      = dec.jal;
                    state_d  = SIF;
                end else if (dec.jr) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_RS;
                    state_d  = SIF;
                end else begin
                    state_d = SEXE;
                end
            end
            SEXE: begin
                // Every execute-stage operation takes rs (or sa) as the A operand.
                alusrca = 1'b1;
                aluc    = dec_aluc;
                if (dec.rtype) begin
                    alusrcb = SRCB_RT;
                    shift   = dec.shift;
                    state_d = SWB;
                end else if (dec.branch) begin
                    alusrcb = SRCB_RT;
                    if (dec.bne ^ z) begin
                        wpc_c    = 1'b1;
                        pcsource = PC_BRANCH;
                    end
                    state_d = SIF;
                end else begin
                    alusrcb = SRCB_IMM;
                    sext    = dec.sext;
                    state_d = (dec.load || dec.store) ? SMEM : SWB;
                end
            end
            SMEM: begin
                iord = 1'b1;
                if (dec.store) begin
                    wmem_c  = 1'b1;
                    state_d = SIF;
                end else begin
                    state_d = SWB;
                end
            end
            SWB: begin
                wreg_c  = 1'b1;
                regrt   = dec.itype || dec.load;
                m2reg   = dec.load;
                state_d = SIF;
            end
            default: state_d = SIF;
        endcase
    end

    // Write enables are masked while reset is held; the FSM already shows SIF.
    assign wpc   = wpc_c  & resetn;
    assign wir   = wir_c  & resetn;
    assign wmem  = wmem_c & resetn;
    assign wreg  = wreg_c & resetn;
    assign state = state_q;

endmodule
